// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic               brw_reg, brw_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    // Holds the WIDTH-1 low result bits; the final bit goes straight into d.
    logic [WIDTH-2:0]   res_reg, res_next, res_shift;
    logic [WIDTH-1:0]   d_reg, d_next;
    logic               bout_reg, bout_next;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_reg, ovf_next;
`endif
    logic               fs_diff, fs_bout;

    full_subtractor u_fs (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (brw_reg),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    generate
        if (WIDTH > 2) begin : g_res_wide
            assign res_shift = {fs_diff, res_reg[WIDTH-2:1]};
        end else begin : g_res_narrow
            assign res_shift = fs_diff;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        brw_next   = brw_reg;
        cnt_next   = cnt_reg;
        res_next   = res_reg;
        d_next     = d_reg;
        bout_next  = bout_reg;
`ifdef SERIAL_SUB_OVF_EN
        ovf_next   = ovf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    brw_next   = bin;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                a_next   = {1'b0, a_reg[WIDTH-1:1]};
                b_next   = {1'b0, b_reg[WIDTH-1:1]};
                brw_next = fs_bout;
                res_next = res_shift;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                    d_next     = {fs_diff, res_reg};
                    bout_next  = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB step differs from borrow out => signed overflow.
                    ovf_next   = brw_reg ^ fs_bout;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            brw_reg   <= 1'b0;
            cnt_reg   <= '0;
            res_reg   <= '0;
            d_reg     <= '0;
            bout_reg  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            brw_reg   <= brw_next;
            cnt_reg   <= cnt_next;
            res_reg   <= res_next;
            d_reg     <= d_next;
            bout_reg  <= bout_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign d    = d_reg;
    assign bout = bout_reg;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 4-bit vector table, corner sequences, and an 8-bit instance.
module tb_serial_subtractor;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] d4;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] d8;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf4, ovf8;
`endif

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    vec_t vecs[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done4(output int t, output bit ok);
        int n;
        n = 0;
        while (!done4 && n < 30) begin
            tick();
            n++;
        end
        ok = done4;
        t  = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] prev_d;
        int lat, bcnt;
        bit held;
        prev_d = d4;
        held = 1'b1;
        a4 = v.a; b4 = v.b; bin4 = v.bin; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = ~v.a; b4 = ~v.b; bin4 = ~v.bin;
        bcnt = busy4 ? 1 : 0;
        if (d4 != prev_d) held = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            tick();
            lat++;
            if (busy4) bcnt++;
            if (!done4 && d4 != prev_d) held = 1'b0;
        end
        check("latency", lat, 4);
        check("busy_cycles", bcnt, 4);
        check("d_hold_during_shift", int'(held), 1);
        check("d", int'(d4), int'(v.d));
        check("bout", int'(bout4), int'(v.bout));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", int'(ovf4), int'(v.ovf));
`endif
        tick();
        check("done_one_cycle", int'(done4), 0);
        check("d_kept_in_idle", int'(d4), int'(v.d));
        $display("[TB] op a=%0d b=%0d bin=%0d -> d=%0d bout=%0d (exp d=%0d bout=%0d) latency=%0d",
                 v.a, v.b, v.bin, d4, bout4, v.d, v.bout, lat);
    endtask

    initial begin
        int t0, t1, t2, lat;
        bit ok, seen;

        //          a      b     bin  d      bout  ovf
        vecs[0]  = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1};
        vecs[1]  = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1, 1'b1};
        vecs[2]  = '{4'd8,  4'd3,  1'b1, 4'd4,  1'b0, 1'b1};
        vecs[3]  = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
        vecs[4]  = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        vecs[5]  = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b0};
        vecs[6]  = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
        vecs[7]  = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0, 1'b0};
        vecs[8]  = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1, 1'b0};
        vecs[9]  = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
        vecs[10] = '{4'd13, 4'd7,  1'b0, 4'd6,  1'b0, 1'b1};

        // Reset for two cycles, with start asserted to show reset wins.
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
        tick();
        tick();
        check("rst_busy", int'(busy4), 0);
        check("rst_done", int'(done4), 0);
        check("rst_d", int'(d4), 0);
        check("rst_bout", int'(bout4), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", int'(ovf4), 0);
`endif
        start4 = 1'b0;
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        a4 = 4'd13; b4 = 4'd7; bin4 = 1'b0; start4 = 1'b1;
        wait_done4(t0, ok);
        check("hold_timeout0", int'(ok), 1);
        check("hold_d0", int'(d4), 6);
        tick();
        wait_done4(t1, ok);
        check("hold_timeout1", int'(ok), 1);
        check("hold_d1", int'(d4), 6);
        tick();
        wait_done4(t2, ok);
        check("hold_timeout2", int'(ok), 1);
        check("hold_d2", int'(d4), 6);
        check("hold_spacing1", t1 - t0, 6);
        check("hold_spacing2", t2 - t1, 6);
        $display("[TB] held start: done at cycles %0d %0d %0d", t0, t1, t2);
        start4 = 1'b0;
        tick();
        tick();

        // Abort with reset two bits into an operation.
        a4 = 4'd14; b4 = 4'd9; bin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", int'(busy4), 0);
        check("abort_done", int'(done4), 0);
        check("abort_d", int'(d4), 0);
        check("abort_bout", int'(bout4), 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done4) seen = 1'b1;
        end
        check("abort_no_done", int'(seen), 0);
        $display("[TB] abort: d=%0d bout=%0d busy=%0d after reset", d4, bout4, busy4);
        run_vec('{4'd14, 4'd9, 1'b0, 4'd5, 1'b0, 1'b0});

        // 8-bit instance.
        a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        lat = 0;
        while (!done8 && lat < 30) begin
            tick();
            lat++;
        end
        check("w8_latency", lat, 8);
        check("w8_d", int'(d8), 145);
        check("w8_bout", int'(bout8), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("w8_ovf", int'(ovf8), 0);
`endif
        $display("[TB] op8 a=200 b=55 bin=0 -> d=%0d bout=%0d latency=%0d", d8, bout8, lat);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
